// File: rtl/riscv_hwloop_pkg.sv
// Shared types and constants for the hardware-loop sequencer slice.
package riscv_hwloop_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        JUMP = 1'b1
    } hwlp_seq_state_e;

    localparam int unsigned HWLP_N_REGS = 2;
    localparam int unsigned HWLP_ADDR_W = 32;

    // Bit positions inside the snooped EX write-enable vector {cnt, end, start}
    localparam int unsigned HWLP_WE_START = 0;
    localparam int unsigned HWLP_WE_END   = 1;
    localparam int unsigned HWLP_WE_CNT   = 2;

    // Register-set id width, kept at least one bit wide for a single set
    function automatic int unsigned hwlp_id_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riscv_hwloop_sequencer_if.sv
// Pipeline, register-file and prefetcher signals seen by the hardware-loop sequencer.
interface riscv_hwloop_sequencer_if #(
    parameter int unsigned N_REGS = riscv_hwloop_pkg::HWLP_N_REGS
) ();
    import riscv_hwloop_pkg::*;

    localparam int unsigned N_REG_BITS = hwlp_id_bits(N_REGS);

    logic [HWLP_ADDR_W-1:0]             instr_addr;
    logic                               instr_valid;
    logic                               instr_ready;
    logic                               flush;
    logic [N_REGS-1:0][HWLP_ADDR_W-1:0] hwlp_start_addr;
    logic [N_REGS-1:0][HWLP_ADDR_W-1:0] hwlp_end_addr;
    logic [N_REGS-1:0][HWLP_ADDR_W-1:0] hwlp_counter;
    logic [2:0]                         hwlp_we;
    logic [N_REG_BITS-1:0]              hwlp_regid;
    logic [N_REGS-1:0]                  hwlp_dec_cnt;
    logic                               jump_req;
    logic [HWLP_ADDR_W-1:0]             jump_target;
    logic                               jump_ack;
    logic                               busy;

    // The sequencer issues decrements and jump requests
    modport master (
        input  instr_addr, instr_valid, instr_ready, flush,
        input  hwlp_start_addr, hwlp_end_addr, hwlp_counter, hwlp_we, hwlp_regid,
        input  jump_ack,
        output hwlp_dec_cnt, jump_req, jump_target, busy
    );

    modport slave (
        output instr_addr, instr_valid, instr_ready, flush,
        output hwlp_start_addr, hwlp_end_addr, hwlp_counter, hwlp_we, hwlp_regid,
        output jump_ack,
        input  hwlp_dec_cnt, jump_req, jump_target, busy
    );

endinterface

// File: rtl/riscv_hwloop_match.sv
// End-address matcher: per-loop hit vector, innermost-loop select and last-iteration flag.
module riscv_hwloop_match
    import riscv_hwloop_pkg::*;
#(
    parameter  int unsigned N_REGS     = HWLP_N_REGS,
    localparam int unsigned N_REG_BITS = hwlp_id_bits(N_REGS)
) (
    input  logic [HWLP_ADDR_W-1:0]             addr,
    input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] end_addr,
    input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] counter,
    output logic [N_REGS-1:0]                  match_c,
    output logic [N_REG_BITS-1:0]              sel_c,
    output logic                               last_c
);

    // A zero counter disables its loop; lowest index wins among equal end addresses
    always_comb begin
        match_c = '0;
        sel_c   = '0;
        for (int k = 0; k < int'(N_REGS); k++) begin
            match_c[k] = (addr == end_addr[k]) && (counter[k] != '0);
        end
        for (int k = int'(N_REGS) - 1; k >= 0; k--) begin
            if (match_c[k]) begin
                sel_c = N_REG_BITS'(k);
            end
        end
        last_c = (counter[sel_c] == HWLP_ADDR_W'(1));
    end

endmodule

// File: rtl/riscv_hwloop_sequencer.sv
// Hardware-loop control: end-address detection, counter decrement and held loop-back jump request.
module riscv_hwloop_sequencer
    import riscv_hwloop_pkg::*;
#(
    parameter int unsigned N_REGS     = HWLP_N_REGS,
    parameter int unsigned N_REG_BITS = hwlp_id_bits(N_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    riscv_hwloop_sequencer_if.master  bus
);

    hwlp_seq_state_e         state_q, state_d;
    logic [N_REGS-1:0]       match_c;
    logic [N_REG_BITS-1:0]   sel_c;
    logic                    last_c;
    logic                    event_c;
    logic                    ex_cnt_wr_c;
    logic                    dec_fire_c;
    logic                    jump_c;
    logic [N_REGS-1:0]       dec_cnt_c;
    logic                    jump_req_q, jump_req_d;
    logic                    busy_q, busy_d;
    logic [HWLP_ADDR_W-1:0]  target_q, target_d;
    logic                    we_unused_c;

    riscv_hwloop_match #(.N_REGS(N_REGS)) u_match (
        .addr     (bus.instr_addr),
        .end_addr (bus.hwlp_end_addr),
        .counter  (bus.hwlp_counter),
        .match_c  (match_c),
        .sel_c    (sel_c),
        .last_c   (last_c)
    );

    // Loop-end event; an EX counter write to the selected set overrides both decrement and jump
    always_comb begin
        event_c     = (|match_c) && bus.instr_valid && bus.instr_ready &&
                      (state_q == IDLE) && !bus.flush;
        ex_cnt_wr_c = bus.hwlp_we[HWLP_WE_CNT] && (bus.hwlp_regid == sel_c);
        dec_fire_c  = event_c && !ex_cnt_wr_c;
        jump_c      = dec_fire_c && !last_c;
    end

    assign we_unused_c = ^bus.hwlp_we[HWLP_WE_END:HWLP_WE_START];

    // State register together with the registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            jump_req_q <= 1'b0;
            busy_q     <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            jump_req_q <= jump_req_d;
            busy_q     <= busy_d;
            target_q   <= target_d;
        end
    end

    // Next state: flush and ack both return to IDLE, so flush needs no extra priority term
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (jump_c) state_d = JUMP;
            JUMP:    if (bus.flush || bus.jump_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: combinational decrement strobe, next values of the registered jump signals
    always_comb begin
        dec_cnt_c  = '0;
        jump_req_d = (state_d == JUMP);
        busy_d     = (state_d == JUMP);
        target_d   = target_q;
        if (dec_fire_c) begin
            dec_cnt_c[sel_c] = 1'b1;
        end
        if ((state_q == IDLE) && jump_c) begin
            target_d = bus.hwlp_start_addr[sel_c];
        end
    end

    assign bus.hwlp_dec_cnt = dec_cnt_c;
    assign bus.jump_req     = jump_req_q;
    assign bus.jump_target  = target_q;
    assign bus.busy         = busy_q;

`ifndef SYNTHESIS
    a_dec_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.hwlp_dec_cnt));
    a_no_hs_busy: assert property (@(posedge clk) disable iff (rst)
        bus.busy |-> !(bus.instr_valid && bus.instr_ready));
    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.jump_req && !bus.jump_ack && !bus.flush) |=>
        (bus.jump_req && $stable(bus.jump_target)));
`endif

endmodule

// File: doc/riscv_hwloop_sequencer.md
Name: riscv_hwloop_sequencer

Overview:
- Control side of the hardware-loop register file.
- Each cycle, compares the PC of the instruction being handed to ID against every loop's end address, then picks the innermost active loop.
- Issues a one-hot counter decrement to the register file.
- Issues a registered, held jump request to the prefetcher carrying the loop start address, and holds the request until the prefetcher acknowledges it.

Parameters:
- N_REGS, 2, number of hardware-loop register sets. Index 0 is the innermost loop and has the highest priority.
- N_REG_BITS, $clog2(N_REGS), width of the register-set id.

Ports:
- clk  in  1  clock. One clock domain only.
- rst  in  1  reset, synchronous, active-high.
- instr_addr_i  in  32  PC of the instruction offered to ID.
- instr_valid_i  in  1  instruction offered.
- instr_ready_i  in  1  ID accepts the instruction. A handshake is instr_valid_i & instr_ready_i.
- flush_i  in  1  branch, exception or debug redirect. Cancels any pending loop jump.
- hwlp_start_addr_i  in  N_REGS x 32  start addresses from the register file.
- hwlp_end_addr_i  in  N_REGS x 32  end addresses from the register file.
- hwlp_counter_i  in  N_REGS x 32  counters from the register file.
- hwlp_we_i  in  3  EX write enables {cnt, end, start}, snooped.
- hwlp_regid_i  in  N_REG_BITS  EX target register set, snooped.
- hwlp_dec_cnt_o  out  N_REGS  one-hot decrement strobe to the register file.
- jump_req_o  out  1  loop-back jump request to the prefetcher.
- jump_target_o  out  32  jump target address.
- jump_ack_i  in  1  prefetcher accepted the jump.
- busy_o  out  1  jump pending. The pipeline must deassert instr_ready_i while busy_o is high.

Behaviour:
- Reset: state IDLE. Reset values: jump_req_o=0, jump_target_o=0, busy_o=0, hwlp_dec_cnt_o=0. Reset asserted mid-JUMP aborts the jump without issuing an ack.
- match[k] = (instr_addr_i == hwlp_end_addr_i[k]) && (hwlp_counter_i[k] != 0).
- sel = lowest k with match[k] set. hit = any match. All comparisons are full 32-bit equality.
- event = hit & instr_valid_i & instr_ready_i & (state==IDLE) & ~flush_i.
- Decrement is combinational:
  - hwlp_dec_cnt_o[sel] = event, unless hwlp_we_i[2] is set and hwlp_regid_i==sel in the same cycle. In that case the strobe is suppressed, because the EX write wins.
  - At most one bit of hwlp_dec_cnt_o is ever set.
- Jump decision is taken in the event cycle, from the counter value before decrement:
  - If counter > 1, the loop iterates again.
  - If counter == 1, this is the last iteration: decrement only, no jump, execution falls through.
  - If the decrement was suppressed by an EX write, no jump is issued either.
- State machine: IDLE, JUMP.
  - IDLE -> JUMP on event with a jump required. jump_target_o latches hwlp_start_addr_i[sel] in that cycle.
  - In JUMP: jump_req_o=1 and busy_o=1, both registered. The first possible assertion is the cycle after the event, i.e. latency 1.
  - JUMP -> IDLE on jump_ack_i. jump_req_o drops in the next cycle.
  - JUMP -> IDLE on flush_i, with no ack required and the jump dropped. flush_i takes priority when it coincides with jump_ack_i.
  - Events are ignored while in JUMP: no decrement and no match processing.
- jump_target_o holds its last value while idle and does not track start-address writes after latching. A start write landing while in JUMP does not alter the pending target.
- A zero counter means the loop is disabled: end-address hits on that loop are ignored.
- Nested loops with equal end addresses: only the lowest index is served per handshake.
- Assertions (non-Verilator):
  - $onehot0(hwlp_dec_cnt_o).
  - No handshake while busy_o is high.
  - jump_req_o stable until ack or flush.

Decomposition:
- riscv_hwloop_pkg holds:
  - the state enum hwlp_seq_state_e {IDLE, JUMP};
  - a default HWLP_N_REGS=2;
  - the constants for the hwlp_we_i bit positions HWLP_WE_START=0, HWLP_WE_END=1, HWLP_WE_CNT=2.
- One sub-module is natural: riscv_hwloop_match. It is combinational and computes the match vector, the lowest-index priority select, and the last-iteration flag. The top level holds the FSM and the registers.

Test Plan:
- Loop 0 with start=0x100, end=0x110, counter=3. Handshake at 0x110 -> dec_cnt=01 in the same cycle; the next cycle jump_req=1, target=0x100, busy=1. Hold ack low for 3 cycles -> request stays stable. Ack -> IDLE.
- Same loop with counter=1. Handshake at 0x110 -> dec_cnt=01, no jump_req, busy stays 0.
- Nested loops: loop0 end=0x200 cnt=2 start=0x1F0; loop1 end=0x200 cnt=5 start=0x180. Handshake at 0x200 -> dec_cnt=01, target=0x1F0.
- Handshake at the end address with hwlp_we_i=3'b100 and regid=0 in the same cycle -> dec_cnt=00 and no jump.
- In JUMP, assert flush_i together with jump_ack_i -> IDLE next cycle, jump_req=0. A handshake at 0x110 one cycle later is processed normally.
- Assert rst in JUMP -> the next cycle shows jump_req=0, busy=0, target=0. A counter=0 loop with an end-address hit -> no strobe.
